// File: rtl/seven_seg_scanner.sv
// Time-multiplexed seven-segment scanner. clk_div is treated as data: it is
// synchronised, its rising edges step the active digit, and new display
// values are swapped in only at frame boundaries so a frame is never torn.
module seven_seg_scanner #(
    parameter int unsigned NUM_DIGITS          = 4,
    parameter bit          ANODE_ACTIVE_LOW    = 1'b1,
    parameter bit          SEG_ACTIVE_LOW      = 1'b1,
    parameter bit          BLANK_LEADING_ZEROS = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_div,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    value_valid,
    output logic                    value_ready,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    frame_done
);

    localparam int unsigned      IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    // Active-high gfedcba pattern for one hex nibble.
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h3F;
            4'h1:    pat = 7'h06;
            4'h2:    pat = 7'h5B;
            4'h3:    pat = 7'h4F;
            4'h4:    pat = 7'h66;
            4'h5:    pat = 7'h6D;
            4'h6:    pat = 7'h7D;
            4'h7:    pat = 7'h07;
            4'h8:    pat = 7'h7F;
            4'h9:    pat = 7'h6F;
            4'hA:    pat = 7'h77;
            4'hB:    pat = 7'h7C;
            4'hC:    pat = 7'h39;
            4'hD:    pat = 7'h5E;
            4'hE:    pat = 7'h79;
            4'hF:    pat = 7'h71;
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

    // Nibble of the display word belonging to digit idx.
    function automatic logic [3:0] digit_nibble(input logic [4*NUM_DIGITS-1:0] disp,
                                                input logic [IDX_W-1:0]        idx);
        logic [3:0] nib;
        nib = 4'h0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nib = nib | ((IDX_W'(i) == idx) ? disp[4*i +: 4] : 4'h0);
        end
        return nib;
    endfunction

    // A digit is a leading zero when it and every more significant nibble
    // are zero; digit 0 always stays lit so a zero value still shows "0".
    function automatic logic digit_blank(input logic [4*NUM_DIGITS-1:0] disp,
                                         input logic [IDX_W-1:0]        idx);
        logic nonzero;
        nonzero = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nonzero = nonzero | ((IDX_W'(i) >= idx) && (disp[4*i +: 4] != 4'h0));
        end
        return BLANK_LEADING_ZEROS && (idx != {IDX_W{1'b0}}) && !nonzero;
    endfunction

    // Segment drive for a digit, in output polarity.
    function automatic logic [6:0] seg_drive(input logic [3:0] nib, input logic blank);
        logic [6:0] pat;
        pat = blank ? 7'h00 : hex_decode(nib);
        return SEG_ACTIVE_LOW ? ~pat : pat;
    endfunction

    // One-hot anode drive for a digit index, in output polarity.
    function automatic logic [NUM_DIGITS-1:0] an_drive(input logic [IDX_W-1:0] idx);
        logic [NUM_DIGITS-1:0] oh;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            oh[i] = (IDX_W'(i) == idx);
        end
        return ANODE_ACTIVE_LOW ? ~oh : oh;
    endfunction

    logic                    s1_r, s2_r, s3_r;
    logic [IDX_W-1:0]        idx_r;
    logic [4*NUM_DIGITS-1:0] display_r;
    logic [4*NUM_DIGITS-1:0] pending_r;
    logic                    pending_full_r;
    logic [NUM_DIGITS-1:0]   an_r;
    logic [6:0]              seg_r;
    logic                    frame_done_r;

    logic                    tick_s;
    logic                    wrap_s;
    logic                    transfer_s;
    logic [IDX_W-1:0]        idx_next_s;
    logic [4*NUM_DIGITS-1:0] display_next_s;
    logic [4*NUM_DIGITS-1:0] pending_next_s;
    logic                    pending_full_next_s;
    logic [NUM_DIGITS-1:0]   an_next_s;
    logic [6:0]              seg_next_s;

    assign tick_s      = s2_r & ~s3_r;
    assign wrap_s      = tick_s && (idx_r == LAST_IDX);
    assign value_ready = ~pending_full_r;
    assign transfer_s  = value_valid & ~pending_full_r;

    assign an          = an_r;
    assign seg         = seg_r;
    assign frame_done  = frame_done_r;

    // Next digit index, frame-boundary display swap and pending-slot update.
    always_comb begin
        idx_next_s          = idx_r;
        display_next_s      = display_r;
        pending_next_s      = pending_r;
        pending_full_next_s = pending_full_r;

        if (wrap_s) begin
            idx_next_s = {IDX_W{1'b0}};
        end else if (tick_s) begin
            idx_next_s = idx_r + IDX_W'(1);
        end else begin
            idx_next_s = idx_r;
        end

        if (transfer_s) begin
            pending_next_s      = value;
            pending_full_next_s = 1'b1;
        end else if (wrap_s && pending_full_r) begin
            display_next_s      = pending_r;
            pending_full_next_s = 1'b0;
        end else begin
            pending_full_next_s = pending_full_r;
        end

        an_next_s  = an_drive(idx_next_s);
        seg_next_s = seg_drive(digit_nibble(display_next_s, idx_next_s),
                               digit_blank(display_next_s, idx_next_s));
    end

    // Synchroniser, scan state, handshake slot and registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r           <= 1'b0;
            s2_r           <= 1'b0;
            s3_r           <= 1'b0;
            idx_r          <= {IDX_W{1'b0}};
            display_r      <= {(4*NUM_DIGITS){1'b0}};
            pending_r      <= {(4*NUM_DIGITS){1'b0}};
            pending_full_r <= 1'b0;
            an_r           <= an_drive({IDX_W{1'b0}});
            seg_r          <= seg_drive(4'h0, 1'b0);
            frame_done_r   <= 1'b0;
        end else begin
            s1_r           <= clk_div;
            s2_r           <= s1_r;
            s3_r           <= s2_r;
            idx_r          <= idx_next_s;
            display_r      <= display_next_s;
            pending_r      <= pending_next_s;
            pending_full_r <= pending_full_next_s;
            frame_done_r   <= wrap_s;
            if (tick_s) begin
                an_r  <= an_next_s;
                seg_r <= seg_next_s;
            end else begin
                an_r  <= an_r;
                seg_r <= seg_r;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner: one default instance and one with
// leading-zero blanking, both driven from the same clk_div and reset.
module tb_seven_seg_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_div;
    logic [15:0] value;
    logic        value_valid;
    logic        value_ready;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame_done;

    logic [15:0] value_b;
    logic        value_valid_b;
    logic        value_ready_b;
    logic [3:0]  an_b;
    logic [6:0]  seg_b;
    logic        frame_done_b;

    int checks = 0;
    int errors = 0;

    // Active-low segment expectations derived from the active-high table.
    localparam logic [6:0] S0   = 7'h7F ^ 7'h3F;
    localparam logic [6:0] S1   = 7'h7F ^ 7'h06;
    localparam logic [6:0] S3   = 7'h7F ^ 7'h4F;
    localparam logic [6:0] S5   = 7'h7F ^ 7'h6D;
    localparam logic [6:0] SA   = 7'h7F ^ 7'h77;
    localparam logic [6:0] SE   = 7'h7F ^ 7'h79;
    localparam logic [6:0] SF   = 7'h7F ^ 7'h71;
    localparam logic [6:0] SOFF = 7'h7F;

    always #5 clk = ~clk;

    seven_seg_scanner #(
        .NUM_DIGITS(4), .ANODE_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1),
        .BLANK_LEADING_ZEROS(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .clk_div(clk_div), .value(value),
        .value_valid(value_valid), .value_ready(value_ready),
        .an(an), .seg(seg), .frame_done(frame_done)
    );

    seven_seg_scanner #(
        .NUM_DIGITS(4), .ANODE_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1),
        .BLANK_LEADING_ZEROS(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst), .clk_div(clk_div), .value(value_b),
        .value_valid(value_valid_b), .value_ready(value_ready_b),
        .an(an_b), .seg(seg_b), .frame_done(frame_done_b)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clk_div period (4 high, 4 low); checks outputs right after the
    // third edge following the rise, when the new digit is first driven.
    task automatic step(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                        input logic e_fd, input logic e_rdy, input logic [6:0] e_seg_b);
        @(posedge clk); #1 clk_div = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({tag, "_an"},    16'(an),          16'(e_an));
        chk({tag, "_seg"},   16'(seg),         16'(e_seg));
        chk({tag, "_fd"},    16'(frame_done),  16'(e_fd));
        chk({tag, "_rdy"},   16'(value_ready), 16'(e_rdy));
        chk({tag, "_seg_b"}, 16'(seg_b),       16'(e_seg_b));
        chk({tag, "_an_b"},  16'(an_b),        16'(e_an));
        @(posedge clk); #1 clk_div = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic send(input logic [15:0] v);
        @(posedge clk); #1 value = v; value_valid = 1'b1;
        @(posedge clk); #1 value_valid = 1'b0;
        @(negedge clk);
        chk("send_rdy_drop", 16'(value_ready), 16'h0000);
    endtask

    initial begin
        rst = 1'b1; clk_div = 1'b0;
        value = 16'h9999; value_valid = 1'b1;
        value_b = 16'h0000; value_valid_b = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy",   16'(value_ready), 16'h0001);
        chk("rst_an",    16'(an),          16'h000E);
        chk("rst_seg",   16'(seg),         16'(S0));
        chk("rst_fd",    16'(frame_done),  16'h0000);
        chk("rst_seg_b", 16'(seg_b),       16'(S0));
        @(posedge clk); #1 rst = 1'b0; value_valid = 1'b0;
        @(negedge clk);
        chk("rst_discard_rdy", 16'(value_ready), 16'h0001);
        chk("rst_discard_seg", 16'(seg),         16'(S0));

        // Blanking instance gets 0x0050 during the first frame.
        @(posedge clk); #1 value_b = 16'h0050; value_valid_b = 1'b1;
        @(posedge clk); #1 value_valid_b = 1'b0;
        @(negedge clk);
        chk("b_rdy_drop", 16'(value_ready_b), 16'h0000);

        // Frame A: all zeros; blanking instance blanks digits 1..3.
        step("a1", 4'b1101, S0, 1'b0, 1'b1, SOFF);
        step("a2", 4'b1011, S0, 1'b0, 1'b1, SOFF);
        step("a3", 4'b0111, S0, 1'b0, 1'b1, SOFF);
        step("a0", 4'b1110, S0, 1'b1, 1'b1, S0);
        @(negedge clk);
        chk("fd_one_cycle", 16'(frame_done), 16'h0000);

        // Frame B: mid-frame transfer of 1A3F, then hold a second value.
        step("b1", 4'b1101, S0, 1'b0, 1'b1, S5);
        send(16'h1A3F);
        @(posedge clk); #1 value = 16'hBEEF; value_valid = 1'b1;
        step("b2", 4'b1011, S0, 1'b0, 1'b0, SOFF);
        step("b3", 4'b0111, S0, 1'b0, 1'b0, SOFF);
        step("b0", 4'b1110, SF, 1'b1, 1'b1, S0);
        #1 value_valid = 1'b0;
        @(negedge clk);
        chk("second_accept_rdy", 16'(value_ready), 16'h0000);

        // Frame C: 1A3F unchanged while BEEF waits.
        step("c1", 4'b1101, S3, 1'b0, 1'b0, S5);
        step("c2", 4'b1011, SA, 1'b0, 1'b0, SOFF);
        step("c3", 4'b0111, S1, 1'b0, 1'b0, SOFF);
        step("c0", 4'b1110, SF, 1'b1, 1'b1, S0);

        // Frame D: BEEF shown; park at digit 2 with a pending value.
        step("d1", 4'b1101, SE, 1'b0, 1'b1, S5);
        step("d2", 4'b1011, SE, 1'b0, 1'b1, SOFF);
        send(16'h2222);

        // One-cycle reset mid-frame drops the pending value.
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mrst_an",  16'(an),          16'h000E);
        chk("mrst_seg", 16'(seg),         16'(S0));
        chk("mrst_rdy", 16'(value_ready), 16'h0001);
        chk("mrst_fd",  16'(frame_done),  16'h0000);
        step("r1", 4'b1101, S0, 1'b0, 1'b1, SOFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Time-multiplexed seven-segment display driver sitting directly downstream of the clock divider. It consumes the divider's slow `clk_div` square wave as a data input, not as a clock. It synchronises `clk_div` into the system clock domain and detects its rising edges. Each edge steps the active digit of a NUM_DIGITS-digit hex display. New display values arrive through a valid/ready handshake and are applied only at frame boundaries, so a frame never shows a mix of old and new digits.

## Interface
- NUM_DIGITS, 4: number of digits scanned; legal range 1..8.
- ANODE_ACTIVE_LOW, 1: 1 = `an` bits are active-low; 0 = active-high.
- SEG_ACTIVE_LOW, 1: 1 = `seg` bits are active-low; 0 = active-high.
- BLANK_LEADING_ZEROS, 0: 1 = suppress leading zero digits.

- clk  in  1  system clock; the only clock in the block.
- rst  in  1  synchronous, active-high reset.
- clk_div  in  1  slow square wave from the divider; high and low phases are each ≥2 clk cycles.
- value  in  4*NUM_DIGITS  hex value to display; nibble i drives digit i, and digit 0 is least significant.
- value_valid  in  1  `value` is presented for transfer.
- value_ready  out  1  equals !pending_full; the block can accept a value.
- an  out  NUM_DIGITS  one-hot digit enable, with polarity set by ANODE_ACTIVE_LOW.
- seg  out  7  segment bits {g,f,e,d,c,b,a}, with polarity set by SEG_ACTIVE_LOW.
- frame_done  out  1  one-cycle pulse marking the start of a new frame.

## Operation
- Synchroniser:
  - `clk_div` passes through flops s1→s2, followed by a history flop s3. All three reset to 0.
  - tick = s2 & !s3.
- Handshake:
  - A transfer occurs when value_valid & value_ready at a clk edge. The value is stored in `pending` and pending_full is set to 1.
  - While pending_full = 1, value_ready = 0 and `value` is ignored.
- Scan:
  - On each tick, digit index idx advances, wrapping from NUM_DIGITS-1 to 0.
  - A wrap is a frame boundary. At a frame boundary with pending_full = 1, `pending` is copied into display_reg and pending_full is cleared.
  - `an` and `seg` are registered. On the tick edge they are loaded from the new idx and the new display_reg, so digit 0 of a new frame already shows the new value.
- Hex decode, active-high gfedcba:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - When SEG_ACTIVE_LOW = 1, the pattern is inverted.
- Blanking (BLANK_LEADING_ZEROS = 1):
  - Digit i is blank (all segments off) when nibble i and every higher nibble are 0.
  - Digit 0 is never blanked.
- frame_done: goes high for exactly one cycle, the cycle right after the wrapping tick edge. It coincides with the first cycle digit 0 is driven.
- Simultaneous events:
  - A transfer in the same cycle as a wrapping tick, with pending_full = 0 beforehand: the value lands in `pending` only and is displayed from the following frame.
  - A wrapping tick with pending_full = 1: the copy to display_reg happens, and value_ready reads 1 the next cycle.
- Reset values (applied while rst = 1 and on the first clk edge):
  - idx = 0 and display_reg = 0.
  - pending_full = 0, so value_ready = 1 during reset; handshakes while rst = 1 are discarded.
  - `an` selects digit 0 and `seg` shows the "0" pattern.
  - frame_done = 0.
- Reset mid-frame: the scan restarts at digit 0 and any pending value is lost.

## Timing
- `clk_div` rising at the edge before E1 is captured into s1 at E1 and s2 at E2.
- tick is high during the E2→E3 cycle.
- `an`, `seg` and frame_done update at E3. Total latency from the `clk_div` rise to the new digit is 3 clk edges.
- Falling edges of `clk_div` produce no tick, so there is exactly one tick per `clk_div` period.
- If `clk_div` is already high when rst releases, the first tick fires 2 edges after release. This is required behaviour.
- value_ready falls the cycle after a transfer. It rises the cycle after the frame-boundary copy.

## Test plan
- Reset, then 4 `clk_div` periods with default parameters:
  - `an` steps 1110→1101→1011→0111→1110.
  - `seg` is active-low "0" (0x40) on every digit.
  - frame_done pulses once, on the return to 1110.
- Transfer value = 16'h1A3F mid-frame:
  - value_ready drops the next cycle.
  - The current frame still shows 0000.
  - The next frame shows digit0 = F(71), digit1 = 3(4F), digit2 = A(77), digit3 = 1(06), active-high view.
  - value_ready returns to 1 the cycle after the wrap.
- Hold value_valid high with a second value while pending_full = 1: the second value is not accepted until after the frame boundary, and the first value is displayed unchanged.
- BLANK_LEADING_ZEROS = 1, value = 16'h0050: digits 3 and 2 have all segments off; digit1 = 5 and digit0 = 0 are lit.
- Assert rst for 1 cycle while idx = 2 with a pending value present:
  - idx returns to 0 and display_reg = 0.
  - value_ready = 1 and frame_done = 0.
  - The first post-reset tick selects digit 1.
